pdp8_trace: RTL and testbench

Synthesizable execution monitor for the PDP-8 core, replacing bench-only PC printing and cycle limiting with hardware that also works on the FPGA board. It watches the CPU state, PC, IR, AC and field registers, and counts instruction fetches. It captures trace entries into a parametrised FIFO, either sampled every Nth fetch or on every fetch. It flags halt and cycle-limit events, and a host or UART bridge drains entries through a valid/ready port.

---
 rtl/pdp8_trace.sv | 138 +++++++++++++
 tb/tb_pdp8_trace.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pdp8_trace.sv
// pdp8_trace: execution monitor for the PDP-8 core.
// It counts instruction fetches and flags halt and cycle-limit events.
// It captures CPU state snapshots into a FIFO that a host drains over a
// valid/ready port.
// Optional build macro: PDP8_TRACE_TIMESTAMP_EN. When defined, each entry is
// prefixed with a 32-bit fetch-count timestamp and ENTRY_W is 72 instead of 40.
module pdp8_trace #(
  parameter int DEPTH         = 16,
  parameter int SAMPLE_PERIOD = 5000,
  parameter int CYCLE_W       = 32,
`ifdef PDP8_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W      = 72
`else
  localparam int ENTRY_W      = 40
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic [3:0]         cpu_state,
  input  logic [11:0]        cpu_pc,
  input  logic [11:0]        cpu_mb,
  input  logic [11:0]        cpu_ac,
  input  logic               cpu_l,
  input  logic [2:0]         cpu_if,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               halted,
  output logic [14:0]        halt_pc,
  output logic               limit_reached,
  output logic [7:0]         dropped
);

  localparam logic [3:0] ST_F0   = 4'b0000;
  localparam logic [3:0] ST_HALT = 4'b1100;
  localparam int AW   = $clog2(DEPTH);
  localparam int SC_W = $clog2(SAMPLE_PERIOD + 1);

  logic [3:0]         prev_state;
  logic [SC_W-1:0]    sample_cnt;
  logic [SC_W-1:0]    sc_next;
  logic [CYCLE_W-1:0] cnt_next;
  logic               frozen;
  logic               halt_ev;
  logic               fetch_ev;
  logic               sample_hit;
  logic               capture;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;
  logic [ENTRY_W-1:0] entry;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;

  // The halt takes priority over a fetch in the same cycle, and once either
  // sticky flag is set the monitor stops counting and capturing.
  always_comb begin
    frozen     = halted | limit_reached;
    halt_ev    = (cpu_state == ST_HALT) && !halted;
    fetch_ev   = (cpu_state == ST_F0) && (prev_state != ST_F0) && !frozen && !halt_ev;
    cnt_next   = cycle_count + 1'b1;
    sc_next    = sample_cnt + 1'b1;
    sample_hit = (sc_next == SC_W'(SAMPLE_PERIOD));
    capture    = fetch_ev && ((mode == 2'd2) || ((mode == 2'd1) && sample_hit));
    pop        = rd_valid && rd_ready;
    full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    push_ok    = capture && (!full || pop);
    drop       = capture && !push_ok;
  end

`ifdef PDP8_TRACE_TIMESTAMP_EN
  logic [31:0] ts;
  // The timestamp is the post-increment fetch count, fitted to 32 bits.
  if (CYCLE_W >= 32) begin : g_ts_trunc
    assign ts = cnt_next[31:0];
  end else begin : g_ts_ext
    assign ts = {{(32-CYCLE_W){1'b0}}, cnt_next};
  end
  assign entry = {ts, cpu_if, cpu_pc, cpu_mb, cpu_l, cpu_ac};
`else
  assign entry = {cpu_if, cpu_pc, cpu_mb, cpu_l, cpu_ac};
`endif

  // Fetch edge detection, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state    <= 4'b1111;
      cycle_count   <= '0;
      sample_cnt    <= '0;
      halted        <= 1'b0;
      halt_pc       <= '0;
      limit_reached <= 1'b0;
      dropped       <= '0;
    end else begin
      prev_state <= cpu_state;
      if (halt_ev) begin
        halted  <= 1'b1;
        halt_pc <= {cpu_if, cpu_pc};
      end
      if (fetch_ev) begin
        cycle_count <= cnt_next;
        if ((max_cycles != '0) && (cnt_next >= max_cycles))
          limit_reached <= 1'b1;
        // The sample counter only advances in sampled mode and holds otherwise.
        if (mode == 2'd1)
          sample_cnt <= sample_hit ? '0 : sc_next;
      end
      if (drop && (dropped != 8'hFF))
        dropped <= dropped + 1'b1;
    end
  end

  // FIFO pointers use one extra bit so that full and empty can be told apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // The storage array itself is not reset; the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= entry;
  end

  assign rd_valid = (wptr != rptr);
  assign rd_data  = rd_valid ? mem[rptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_pdp8_trace.sv
// Directed self-checking bench for pdp8_trace (DEPTH=4, SAMPLE_PERIOD=4).
module tb_pdp8_trace;
`ifdef PDP8_TRACE_TIMESTAMP_EN
  localparam int EW = 72;
`else
  localparam int EW = 40;
`endif
  localparam logic [3:0] F0 = 4'b0000, E0 = 4'b0010, HLT = 4'b1100;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [31:0]   max_cycles;
  logic [3:0]    cpu_state;
  logic [11:0]   cpu_pc, cpu_mb, cpu_ac;
  logic          cpu_l;
  logic [2:0]    cpu_if;
  logic [EW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic [31:0]   cycle_count;
  logic          halted, limit_reached;
  logic [14:0]   halt_pc;
  logic [7:0]    dropped;

  int n_cmp = 0;
  int n_fail = 0;
  logic [EW-1:0] popq[$];

  pdp8_trace #(.DEPTH(4), .SAMPLE_PERIOD(4), .CYCLE_W(32)) dut (
    .clk(clk), .reset(reset), .mode(mode), .max_cycles(max_cycles),
    .cpu_state(cpu_state), .cpu_pc(cpu_pc), .cpu_mb(cpu_mb), .cpu_ac(cpu_ac),
    .cpu_l(cpu_l), .cpu_if(cpu_if), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .cycle_count(cycle_count), .halted(halted),
    .halt_pc(halt_pc), .limit_reached(limit_reached), .dropped(dropped));

  always #5 clk = ~clk;

  // Record every entry the consumer accepts.
  always @(posedge clk) begin
    if (!reset && rd_valid && rd_ready) popq.push_back(rd_data);
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected 40-bit entry body for a fetch driven by fetch() below.
  function automatic logic [39:0] body(input logic [2:0] f, input logic [11:0] pc);
    logic [11:0] mb, ac;
    mb = pc ^ 12'o7777;
    ac = pc + 12'o0011;
    return {f, pc, mb, pc[0], ac};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle F0 with derived mb/ac/l, followed by one E0 cycle.
  task automatic fetch(input logic [11:0] pc);
    @(negedge clk);
    cpu_state = F0; cpu_pc = pc; cpu_mb = pc ^ 12'o7777;
    cpu_ac = pc + 12'o0011; cpu_l = pc[0];
    @(negedge clk);
    cpu_state = E0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    popq.delete();
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; max_cycles = '0; cpu_state = E0;
    cpu_pc = '0; cpu_mb = '0; cpu_ac = '0; cpu_l = 1'b0; cpu_if = 3'd0;
    rd_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_valid", 72'(rd_valid), 72'd0);
    chk("rst_data", 72'(rd_data), 72'd0);
    chk("rst_count", 72'(cycle_count), 72'd0);
    chk("rst_halted", 72'(halted), 72'd0);
    chk("rst_halt_pc", 72'(halt_pc), 72'd0);
    chk("rst_limit", 72'(limit_reached), 72'd0);
    chk("rst_dropped", 72'(dropped), 72'd0);

    // Sampled mode: captures on the 4th and 8th fetch.
    mode = 2'd1; rd_ready = 1'b1; cpu_if = 3'd1;
    for (int i = 0; i < 10; i++) fetch(12'o0200 + 12'(i));
    cyc(3);
    chk("smp_n", 72'(popq.size()), 72'd2);
    chk("smp_count", 72'(cycle_count), 72'd10);
    if (popq.size() == 2) begin
      chk("smp_e0", 72'(popq[0][39:0]), 72'(body(3'd1, 12'o0203)));
      chk("smp_e1", 72'(popq[1][39:0]), 72'(body(3'd1, 12'o0207)));
`ifdef PDP8_TRACE_TIMESTAMP_EN
      chk("smp_ts0", 72'(popq[0][71:40]), 72'd4);
      chk("smp_ts1", 72'(popq[1][71:40]), 72'd8);
`endif
    end

    // Every-fetch mode, stalled reader: 4 held, 2 dropped, drain in order.
    do_reset();
    mode = 2'd2; rd_ready = 1'b0; cpu_if = 3'd3;
    for (int i = 0; i < 6; i++) fetch(12'o0100 + 12'(i));
    cyc(1);
    chk("stall_valid", 72'(rd_valid), 72'd1);
    chk("stall_dropped", 72'(dropped), 72'd2);
    chk("stall_count", 72'(cycle_count), 72'd6);
    chk("stall_head", 72'(rd_data[39:0]), 72'(body(3'd3, 12'o0100)));
    rd_ready = 1'b1;
    cyc(5);
    chk("drain_valid", 72'(rd_valid), 72'd0);
    chk("drain_n", 72'(popq.size()), 72'd4);
    if (popq.size() == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("drain_e%0d", i), 72'(popq[i][39:0]), 72'(body(3'd3, 12'o0100 + 12'(i))));

    // Multi-cycle F0 counts once.
    do_reset();
    mode = 2'd2; rd_ready = 1'b1; cpu_if = 3'd0;
    @(negedge clk);
    cpu_state = F0; cpu_pc = 12'o0400;
    cyc(3);
    cpu_state = E0;
    cyc(3);
    chk("multi_count", 72'(cycle_count), 72'd1);
    chk("multi_n", 72'(popq.size()), 72'd1);

    // Cycle limit of 5.
    do_reset();
    max_cycles = 32'd5; mode = 2'd2; rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) fetch(12'o0500 + 12'(i));
    chk("lim_before", 72'(limit_reached), 72'd0);
    for (int i = 4; i < 8; i++) fetch(12'o0500 + 12'(i));
    cyc(3);
    chk("lim_flag", 72'(limit_reached), 72'd1);
    chk("lim_count", 72'(cycle_count), 72'd5);
    chk("lim_n", 72'(popq.size()), 72'd5);
    if (popq.size() == 5)
      chk("lim_last", 72'(popq[4][39:0]), 72'(body(3'd0, 12'o0504)));
    max_cycles = '0;

    // Halt: latched PC, no entry, later fetches ignored.
    do_reset();
    mode = 2'd2; rd_ready = 1'b0;
    @(negedge clk);
    cpu_state = HLT; cpu_if = 3'd2; cpu_pc = 12'o0345;
    @(negedge clk);
    cpu_state = E0;
    chk("halt_flag", 72'(halted), 72'd1);
    chk("halt_pc", 72'(halt_pc), 72'(15'o20345));
    chk("halt_novalid", 72'(rd_valid), 72'd0);
    fetch(12'o0346);
    fetch(12'o0347);
    @(negedge clk);
    cpu_state = HLT; cpu_pc = 12'o0111;
    @(negedge clk);
    cpu_state = E0;
    cyc(1);
    chk("halt_frozen", 72'(cycle_count), 72'd0);
    chk("halt_noentry", 72'(rd_valid), 72'd0);
    chk("halt_pc_hold", 72'(halt_pc), 72'(15'o20345));

    // Reset mid-stream discards queued entries.
    do_reset();
    mode = 2'd2; rd_ready = 1'b0; cpu_if = 3'd5;
    for (int i = 0; i < 3; i++) fetch(12'o0600 + 12'(i));
    chk("mid_valid", 72'(rd_valid), 72'd1);
    do_reset();
    chk("mid_rst_valid", 72'(rd_valid), 72'd0);
    chk("mid_rst_count", 72'(cycle_count), 72'd0);
    chk("mid_rst_halted", 72'(halted), 72'd0);
    chk("mid_rst_dropped", 72'(dropped), 72'd0);
    fetch(12'o0700);
    chk("post_valid", 72'(rd_valid), 72'd1);
    chk("post_entry", 72'(rd_data[39:0]), 72'(body(3'd5, 12'o0700)));
`ifdef PDP8_TRACE_TIMESTAMP_EN
    chk("post_ts", 72'(rd_data[71:40]), 72'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
